// File: rtl/nn_pkg.sv
// Shared widths, counts, FSM encoding and result record for the frame sequencer.
// Pure declarations: no latency, no flow control.
package nn_pkg;

    localparam int FEAT_W  = 8;
    localparam int FEAT_N  = 8;
    localparam int CLASS_N = 4;
    localparam int CON_W   = 12;
    localparam int CNT_W   = $clog2(FEAT_N);
    localparam int CLS_W   = $clog2(CLASS_N);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SEND   = 2'd2
    } state_t;

    typedef struct packed {
        logic [CLS_W-1:0]  cls;
        logic [FEAT_W-1:0] score;
        logic [CON_W-1:0]  con;
    } result_t;

endpackage

// File: rtl/nn_argmax4.sv
// Unsigned argmax over four softmax bytes; the lowest index wins a tie.
// Purely combinational: zero latency, no flow control.
module nn_argmax4
    import nn_pkg::*;
(
    input  logic [FEAT_W-1:0] i_v0,
    input  logic [FEAT_W-1:0] i_v1,
    input  logic [FEAT_W-1:0] i_v2,
    input  logic [FEAT_W-1:0] i_v3,
    output logic [CLS_W-1:0]  o_idx,
    output logic [FEAT_W-1:0] o_max
);

    // Strict greater-than keeps the earlier index when values are equal.
    always_comb begin
        o_idx = 2'd0;
        o_max = i_v0;
        if (i_v1 > o_max) begin
            o_idx = 2'd1;
            o_max = i_v1;
        end
        if (i_v2 > o_max) begin
            o_idx = 2'd2;
            o_max = i_v2;
        end
        if (i_v3 > o_max) begin
            o_idx = 2'd3;
            o_max = i_v3;
        end
    end

endmodule

// File: rtl/nn_frame_sequencer.sv
// Loads 8 feature bytes into x1..x8, lets the neighbouring network settle, then offers its argmax.
// m_valid rises SETTLE_CYC+1 cycles after the last byte; s_ready is low outside LOAD, and the result is held until m_ready.
module nn_frame_sequencer
    import nn_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [FEAT_W-1:0] s_data,
    output logic              s_ready,
    output logic [FEAT_W-1:0] x1,
    output logic [FEAT_W-1:0] x2,
    output logic [FEAT_W-1:0] x3,
    output logic [FEAT_W-1:0] x4,
    output logic [FEAT_W-1:0] x5,
    output logic [FEAT_W-1:0] x6,
    output logic [FEAT_W-1:0] x7,
    output logic [FEAT_W-1:0] x8,
    input  logic [FEAT_W-1:0] nn_out1,
    input  logic [FEAT_W-1:0] nn_out2,
    input  logic [FEAT_W-1:0] nn_out3,
    input  logic [FEAT_W-1:0] nn_out4,
    input  logic [CON_W-1:0]  nn_out_con,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CLS_W-1:0]  m_class,
    output logic [FEAT_W-1:0] m_score,
    output logic [CON_W-1:0]  m_con,
    output logic              busy
);

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] BYTE_LAST   = CNT_W'(FEAT_N - 1);

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [CNT_W-1:0]               r_byte_cnt;
    logic [3:0]                     r_settle_cnt;
    logic [FEAT_N-1:0][FEAT_W-1:0]  r_x;
    result_t                        r_res;

    logic              w_accept;
    logic              w_settle_done;
    logic [CLS_W-1:0]  w_idx;
    logic [FEAT_W-1:0] w_max;

    nn_argmax4 u_argmax (
        .i_v0  (nn_out1),
        .i_v1  (nn_out2),
        .i_v2  (nn_out3),
        .i_v3  (nn_out4),
        .o_idx (w_idx),
        .o_max (w_max)
    );

    assign w_accept      = s_valid && (r_state == ST_LOAD);
    assign w_settle_done = (r_state == ST_SETTLE) && (r_settle_cnt == SETTLE_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD:   if (w_accept && (r_byte_cnt == BYTE_LAST)) w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (w_settle_done) w_state_nxt = ST_SEND;
            ST_SEND:   if (m_ready) w_state_nxt = ST_LOAD;
            default:   w_state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Byte count wraps 7 -> 0 on the final accept, ready for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt <= '0;
            r_x        <= '0;
        end else if (w_accept) begin
            r_byte_cnt        <= r_byte_cnt + 1'b1;
            r_x[r_byte_cnt]   <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_settle_cnt <= '0;
        end else if (r_state == ST_SETTLE) begin
            r_settle_cnt <= w_settle_done ? 4'd0 : r_settle_cnt + 4'd1;
        end else begin
            r_settle_cnt <= '0;
        end
    end

    // Network outputs are only trusted on the last settle cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res <= '0;
        end else if (w_settle_done) begin
            r_res <= '{cls: w_idx, score: w_max, con: nn_out_con};
        end
    end

    assign s_ready = (r_state == ST_LOAD);
    assign m_valid = (r_state == ST_SEND);
    assign m_class = r_res.cls;
    assign m_score = r_res.score;
    assign m_con   = r_res.con;
    assign busy    = !((r_state == ST_LOAD) && (r_byte_cnt == '0));

    assign x1 = r_x[0];
    assign x2 = r_x[1];
    assign x3 = r_x[2];
    assign x4 = r_x[3];
    assign x5 = r_x[4];
    assign x6 = r_x[5];
    assign x7 = r_x[6];
    assign x8 = r_x[7];

endmodule

// File: tb/tb_nn_frame_sequencer.sv
// Randomized and directed frames; a scoreboard queue is filled by stimulus and drained by a monitor.
module tb_nn_frame_sequencer;

    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_ready;
    logic [7:0]  x1, x2, x3, x4, x5, x6, x7, x8;
    logic [7:0]  nn_out1 = '0, nn_out2 = '0, nn_out3 = '0, nn_out4 = '0;
    logic [11:0] nn_out_con = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [1:0]  m_class;
    logic [7:0]  m_score;
    logic [11:0] m_con;
    logic        busy;

    nn_frame_sequencer #(.SETTLE_CYC(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7), .x8(x8),
        .nn_out1(nn_out1), .nn_out2(nn_out2), .nn_out3(nn_out3), .nn_out4(nn_out4),
        .nn_out_con(nn_out_con), .m_valid(m_valid), .m_ready(m_ready),
        .m_class(m_class), .m_score(m_score), .m_con(m_con), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] bytes;
        logic [1:0]  cls;
        logic [7:0]  score;
        logic [11:0] con;
        int          exp_cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_hs = -100;
    bit   rdy_random = 1'b0;

    wire [63:0] w_x = {x8, x7, x6, x5, x4, x3, x2, x1};

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rdy_random) m_ready = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: find the largest value, then the first position holding it.
    function automatic void model(input logic [31:0] nn, output logic [1:0] c, output logic [7:0] s);
        int mx = 0;
        for (int i = 0; i < 4; i++) if (int'(nn[8*i +: 8]) > mx) mx = int'(nn[8*i +: 8]);
        c = 2'd0;
        for (int i = 3; i >= 0; i--) if (int'(nn[8*i +: 8]) == mx) c = 2'(i);
        s = 8'(mx);
    endfunction

    // Monitor: latency and x vector on m_valid rise, hold during stall, result on handshake.
    bit          prev_mv = 1'b0;
    bit          prev_hs = 1'b0;
    logic [21:0] prev_out = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_mv = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (m_valid && !prev_mv) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got m_valid=1 want 0 (cycle %0d)", cyc);
                end else begin
                    chk("latency", 64'(cyc), 64'(sb[0].exp_cyc));
                    chk("x_vec", w_x, sb[0].bytes);
                end
            end
            if (m_valid && prev_mv && !prev_hs) begin
                chk("stall_hold", 64'({m_class, m_score, m_con}), 64'(prev_out));
                chk("stall_s_ready", 64'(s_ready), 64'd0);
            end
            if (m_valid && m_ready && sb.size() > 0) begin
                chk("m_class", 64'(m_class), 64'(sb[0].cls));
                chk("m_score", 64'(m_score), 64'(sb[0].score));
                chk("m_con", 64'(m_con), 64'(sb[0].con));
                void'(sb.pop_front());
                last_hs = cyc;
            end
            prev_mv  = m_valid;
            prev_hs  = m_valid && m_ready;
            prev_out = {m_class, m_score, m_con};
        end
    end

    task automatic do_reset();
        @(negedge clk);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_x", w_x, 64'd0);
        chk("rst_result", 64'({m_class, m_score, m_con}), 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
    endtask

    task automatic run_frame(input logic [63:0] bytes, input logic [31:0] nn, input logic [11:0] con,
                             input int gap, input int nbytes, input bit chk_b2b);
        int   t = 0;
        int   guard = 0;
        exp_t e;
        @(negedge clk);
        while (!s_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready) begin
            total++;
            bad++;
            $display("FAIL frame_start_timeout: got s_ready=0 want 1");
            return;
        end
        {nn_out4, nn_out3, nn_out2, nn_out1} = nn;
        nn_out_con = con;
        for (int k = 0; k < nbytes; k++) begin
            s_valid = 1'b1;
            s_data  = bytes[8*k +: 8];
            if (k > 0) @(negedge clk);
            t = cyc;
            if (k == 0 && chk_b2b) chk("b2b_first_accept", 64'(t), 64'(last_hs + 1));
            if (k > 0) chk("load_s_ready", 64'(s_ready), 64'd1);
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            if (k < nbytes - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        if (nbytes == 8) begin
            e.bytes   = bytes;
            model(nn, e.cls, e.score);
            e.con     = con;
            e.exp_cyc = t + SETTLE + 1;
            sb.push_back(e);
        end
    endtask

    task automatic wait_valid(input string name);
        int guard = 0;
        while (!m_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!m_valid) begin
            total++;
            bad++;
            $display("FAIL %s: got m_valid=0 want 1 after %0d cycles", name, guard);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    logic [63:0] rb;
    logic [31:0] rnn;
    logic [63:0] snap;

    initial begin
        do_reset();

        // Contiguous 1..8 with a clear winner in slot 1.
        m_ready = 1'b1;
        run_frame(64'h0807060504030201, {8'd3, 8'd20, 8'd50, 8'd10}, 12'h123, 0, 8, 1'b0);
        drain();

        // Four-way tie.
        run_frame(64'h1122334455667788, {8'd40, 8'd40, 8'd40, 8'd40}, 12'hABC, 0, 8, 1'b0);
        drain();

        // Stall in SEND with s_valid held high.
        m_ready = 1'b0;
        run_frame(64'hF0E0D0C0B0A09080, {8'd200, 8'd7, 8'd200, 8'd1}, 12'h5A5, 0, 8, 1'b0);
        @(negedge clk);
        wait_valid("stall_wait");
        s_valid = 1'b1;
        s_data  = 8'h5A;
        snap    = w_x;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_no_accept", w_x, snap);
            chk("stall_m_valid", 64'(m_valid), 64'd1);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        drain();

        // Sparse s_valid: 1,0,0,1,...
        run_frame(64'h8877665544332211, {8'd9, 8'd9, 8'd250, 8'd0}, 12'h00F, 2, 8, 1'b0);
        drain();

        // Reset after 3 bytes aborts the frame.
        run_frame(64'h00000000000000AA, 32'h01020304, 12'h111, 0, 3, 1'b0);
        do_reset();
        run_frame(64'h0102030405060708, {8'd1, 8'd2, 8'd3, 8'd4}, 12'hFED, 0, 8, 1'b0);
        drain();

        // Reset while the result is being offered.
        m_ready = 1'b0;
        run_frame(64'h0A0B0C0D0E0F1011, {8'd5, 8'd6, 8'd7, 8'd8}, 12'h777, 0, 8, 1'b0);
        @(negedge clk);
        wait_valid("send_reset_wait");
        do_reset();
        chk("send_reset_no_valid", 64'(m_valid), 64'd0);
        m_ready = 1'b1;

        // Back-to-back with m_ready tied high.
        run_frame(64'h1111111111111111, {8'd0, 8'd0, 8'd0, 8'd99}, 12'h321, 0, 8, 1'b0);
        run_frame(64'h2222222222222222, {8'd77, 8'd0, 8'd0, 8'd0}, 12'h654, 0, 8, 1'b1);
        drain();

        // Randomized frames with random downstream backpressure.
        rdy_random = 1'b1;
        for (int f = 0; f < 10; f++) begin
            rb  = {$urandom, $urandom};
            rnn = $urandom;
            if (f % 3 == 0) rnn[8*$urandom_range(0, 3) +: 8] = rnn[8*$urandom_range(0, 3) +: 8];
            run_frame(rb, rnn, 12'($urandom), $urandom_range(0, 2), 8, 1'b0);
        end
        drain();
        rdy_random = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nn_frame_sequencer.md
NN_FRAME_SEQUENCER -- requirements
Module: nn_frame_sequencer

Interface
REQ-001 Parameter SETTLE_CYC, default 2, meaning cycles the network input is held stable before results are captured (legal range 1..15).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 s_valid  input  1  input byte valid.
REQ-005 s_data  input  8  signed input feature byte.
REQ-006 s_ready  output  1  sequencer accepts s_data.
REQ-007 x1..x8  output  8 each  feature vector driven into the neural_network instance.
REQ-008 nn_out1..nn_out4  input  8 each  unsigned softmax outputs from the network.
REQ-009 nn_out_con  input  12  concentrated-neuron output from the network.
REQ-010 m_valid  output  1  result valid.
REQ-011 m_ready  input  1  downstream accepts result.
REQ-012 m_class  output  2  argmax index (0 = nn_out1 ... 3 = nn_out4).
REQ-013 m_score  output  8  winning softmax value.
REQ-014 m_con  output  12  captured nn_out_con.
REQ-015 busy  output  1  high in any state other than LOAD with byte count 0.

Function
REQ-016 FSM states: LOAD, SETTLE, SEND; reset state is LOAD.
REQ-017 LOAD: s_ready = 1; a byte is accepted on a cycle where s_valid & s_ready.
REQ-018 Accepted byte k (0..7) is registered into x(k+1); byte count increments by 1 per accept; idle cycles (s_valid = 0) leave all state unchanged.
REQ-019 Accept of byte 7 transitions to SETTLE on the next edge, with byte count cleared to 0.
REQ-020 SETTLE: s_ready = 0; x1..x8 held constant; settle counter counts SETTLE_CYC cycles.
REQ-021 On the final SETTLE cycle, nn_out1..4 and nn_out_con are sampled into result registers and state goes to SEND; m_valid rises on the following cycle.
REQ-022 Argmax: unsigned comparison; ties resolve to the lowest index; m_score = value at m_class.
REQ-023 SEND: m_valid = 1; m_class, m_score, m_con stable until handshake; s_ready = 0; x1..x8 held.
REQ-024 Handshake m_valid & m_ready: next cycle state = LOAD, m_valid = 0, s_ready = 1; result registers keep last values.
REQ-025 Latency: last input byte accepted at cycle T -> m_valid high at cycle T + SETTLE_CYC + 1.
REQ-026 Back-to-back frames: no cycle lost beyond REQ-024; the first byte of the next frame is accepted one cycle after the handshake if s_valid is high.
REQ-027 x1..x8 are not cleared between frames; they are overwritten byte by byte.

Reset
REQ-028 rst_n low: state = LOAD, byte count = 0, settle counter = 0, x1..x8 = 0, m_valid = 0, m_class = 0, m_score = 0, m_con = 0.
REQ-029 Reset asserted mid-frame or mid-SEND aborts the frame without emitting a result; after release, s_ready = 1 on the first cycle.

Structure
REQ-030 Shared package nn_pkg holds the feature width (8), the feature count (8), the class count (4), the concentrated-output width (12) and the FSM state enumeration.
REQ-031 One sub-module, nn_argmax4: combinational, 4 x 8-bit unsigned inputs -> 2-bit index plus 8-bit maximum, lowest-index tie rule.
REQ-032 neural_network is instantiated beside this block at the top level, not inside it.

Verification
REQ-033 Bytes 0x01..0x08 streamed contiguously, nn_out = {10, 50, 20, 3}, SETTLE_CYC = 2 -> x1..x8 = 1..8; m_valid 3 cycles after last accept; m_class = 1; m_score = 50.
REQ-034 Tie case nn_out = {40, 40, 40, 40}, nn_out_con = 0xABC -> m_class = 0, m_score = 40, m_con = 0xABC.
REQ-035 m_ready held low 5 cycles in SEND with s_valid high -> m_valid, m_class, m_score and m_con stable; s_ready = 0; no byte accepted.
REQ-036 s_valid toggling 1,0,0,1,... over a frame -> exactly 8 bytes captured, in order; SETTLE entered only after the 8th byte.
REQ-037 rst_n pulsed low after 3 bytes -> x1..x3 = 0, byte count = 0, no m_valid; the next 8 bytes form a correct frame.
REQ-038 Two frames with m_ready tied high -> second frame's first byte accepted 1 cycle after the first result handshake; both results correct.
